dmem_wb_responder: RTL

Wishbone-style data-memory responder that sits on the far side of the pipeline memory stage's data bus. It accepts single-beat read/write requests (cyc/stb/we/sel), applies byte-lane writes to an internal word array, and returns read data with a one-cycle ack after a programmable number of wait states. It also reports out-of-range accesses with err. It is the memory model for stage-level benches and the on-chip data RAM for the core.

---
 rtl/dmem_wb_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_wb_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wb_responder
// Description : Wishbone-style data-memory responder. It accepts single-beat
//               requests, applies byte-lane writes and returns ack/err after
//               a programmable number of wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_wb_responder #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  dm_clk,
    input  logic                  dm_rst,
    input  logic                  dm_i_cyc,
    input  logic                  dm_i_stb,
    input  logic                  dm_i_we,
    input  logic [DWIDTH-1:0]     dm_i_addr,
    input  logic [DWIDTH-1:0]     dm_i_data,
    input  logic [DWIDTH/8-1:0]   dm_i_sel,
    output logic [DWIDTH-1:0]     dm_o_data,
    output logic                  dm_o_ack,
    output logic                  dm_o_err,
    output logic                  dm_o_stall
);

    localparam int         c_LANES  = DWIDTH / 8;
    localparam int         c_DEPTH  = 1 << AWIDTH;
    localparam logic [3:0] c_WAIT   = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic [AWIDTH-1:0]  r_idx;
    logic               r_oor;
    logic [DWIDTH-1:0]  r_wdata;
    logic [c_LANES-1:0] r_sel;
    logic               r_we;
    logic               r_ack;
    logic               r_err;
    logic [DWIDTH-1:0]  r_rdata;
    logic [DWIDTH-1:0]  r_mem [0:c_DEPTH-1];

    logic               w_accept;
    logic               w_access;
    logic               w_mem_we;
    logic               w_oor;
    logic               w_unused_lsbs;

    // Byte offset bits carry no meaning here; alignment is expressed via sel.
    assign w_unused_lsbs = ^dm_i_addr[1:0];

    if (DWIDTH > AWIDTH + 2) begin : g_range
        assign w_oor = |dm_i_addr[DWIDTH-1:AWIDTH+2];
    end else begin : g_no_range
        assign w_oor = 1'b0;
    end

    assign w_accept = ((r_state == c_S_IDLE) || (r_state == c_S_RESP)) && dm_i_cyc && dm_i_stb;
    // An abort (cyc low) takes priority over a due access.
    assign w_access = (r_state == c_S_WAIT) && dm_i_cyc && (r_cnt == 4'd0);
    assign w_mem_we = w_access && r_we && !r_oor;

    always_ff @(posedge dm_clk or posedge dm_rst) begin
        if (dm_rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                c_S_IDLE, c_S_RESP: begin
                    if (w_accept) begin
                        r_idx   <= dm_i_addr[AWIDTH+1:2];
                        r_oor   <= w_oor;
                        r_wdata <= dm_i_data;
                        r_sel   <= dm_i_sel;
                        r_we    <= dm_i_we;
                        r_cnt   <= c_WAIT;
                        r_state <= c_S_WAIT;
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end
                c_S_WAIT: begin
                    if (!dm_i_cyc) begin
                        r_state <= c_S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= c_S_RESP;
                        if (r_oor) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_ack <= 1'b1;
                            if (!r_we) begin
                                r_rdata <= r_mem[r_idx];
                            end
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Memory contents survive reset so the array maps onto plain RAM.
    always_ff @(posedge dm_clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < c_LANES; k++) begin
                if (r_sel[k]) begin
                    r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    assign dm_o_data  = r_rdata;
    assign dm_o_ack   = r_ack;
    assign dm_o_err   = r_err;
    assign dm_o_stall = (r_state == c_S_WAIT);

endmodule
`default_nettype wire
